// File: rtl/mem_stage.sv
// MEM pipeline stage: registers the EX/MEM bundle and runs sw/lw on a
// variable-latency req/ack data-memory port, stalling upstream until done.
module mem_stage #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [15:0] ERR_DATA = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        halt,
    input  logic [15:0] ex_result,
    input  logic [15:0] ex_store_data,
    input  logic [2:0]  ex_opcode,
    input  logic [2:0]  ex_tgt,
    input  logic        ex_bubble,
    input  logic        ex_halt,
    output logic        mem_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_wdata,
    input  logic [15:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic [15:0] mem_result_out,
    output logic [15:0] mem_out_2,
    output logic [2:0]  mem_opcode_out,
    output logic [2:0]  mem_tgt,
    output logic        mem_bubble_out,
    output logic        mem_halt_out,
    output logic        bus_err
);

    localparam int unsigned    CW    = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  TMO   = CW'(TIMEOUT);
    localparam logic [2:0]     OP_SW = 3'b100;
    localparam logic [2:0]     OP_LW = 3'b101;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   addr_q, addr_d;
    logic [15:0]   wdata_q, wdata_d;
    logic          we_q, we_d;
    logic [15:0]   ldata_q, ldata_d;
    logic          berr_q, berr_d;

    logic [15:0]   res_q, res_d;
    logic [15:0]   out2_q, out2_d;
    logic [2:0]    opc_q, opc_d;
    logic [2:0]    tgt_q, tgt_d;
    logic          bub_q, bub_d;
    logic          hlt_q, hlt_d;

    logic          is_sw, is_lw, mem_op;
    logic          load_ex, load_bub;
    logic [15:0]   ex_ld;

    assign is_sw  = (ex_opcode == OP_SW);
    assign is_lw  = (ex_opcode == OP_LW);
    assign mem_op = !ex_bubble && (is_sw || is_lw);

    // Access FSM: next state, memory port drive, stall and commit decisions
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        ldata_d    = ldata_q;
        berr_d     = berr_q;
        load_ex    = 1'b0;
        load_bub   = 1'b0;
        ex_ld      = '0;
        dmem_req   = 1'b0;
        dmem_we    = we_q;
        dmem_addr  = addr_q;
        dmem_wdata = wdata_q;
        mem_stall  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                dmem_we    = is_sw;
                dmem_addr  = ex_result;
                dmem_wdata = ex_store_data;
                if (!halt) begin
                    if (mem_op) begin
                        dmem_req = 1'b1;
                        if (dmem_ack) begin
                            load_ex = 1'b1;
                            ex_ld   = dmem_rdata;
                        end else begin
                            state_d  = S_WAIT;
                            cnt_d    = CW'(1);
                            addr_d   = ex_result;
                            wdata_d  = ex_store_data;
                            we_d     = is_sw;
                            load_bub = 1'b1;
                        end
                    end else begin
                        load_ex = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                dmem_req  = 1'b1;
                mem_stall = 1'b1;
                load_bub  = 1'b1;
                if (dmem_ack) begin
                    ldata_d = dmem_rdata;
                    state_d = S_DONE;
                end else if (cnt_q == TMO) begin
                    berr_d  = 1'b1;
                    ldata_d = ERR_DATA;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (halt) begin
                    mem_stall = 1'b1;
                    load_bub  = 1'b1;
                end else begin
                    // The op's bundle is still held upstream, so it commits from the EX inputs
                    load_ex = 1'b1;
                    ex_ld   = ldata_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (rst) begin
            dmem_req  = 1'b0;
            mem_stall = 1'b0;
        end
    end

    // Output register next values: commit the EX bundle, insert a bubble, or hold
    always_comb begin
        res_d  = res_q;
        out2_d = out2_q;
        opc_d  = opc_q;
        tgt_d  = tgt_q;
        bub_d  = bub_q;
        hlt_d  = hlt_q;
        if (load_ex) begin
            res_d  = ex_result;
            opc_d  = ex_opcode;
            tgt_d  = ex_bubble ? 3'b000 : ex_tgt;
            bub_d  = ex_bubble;
            hlt_d  = ex_halt && !ex_bubble;
            out2_d = (is_lw && !ex_bubble) ? ex_ld : 16'h0000;
        end else if (load_bub) begin
            bub_d = 1'b1;
            tgt_d = '0;
            hlt_d = 1'b0;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            ldata_q <= '0;
            berr_q  <= 1'b0;
            res_q   <= '0;
            out2_q  <= '0;
            opc_q   <= '0;
            tgt_q   <= '0;
            bub_q   <= 1'b1;
            hlt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            ldata_q <= ldata_d;
            berr_q  <= berr_d;
            res_q   <= res_d;
            out2_q  <= out2_d;
            opc_q   <= opc_d;
            tgt_q   <= tgt_d;
            bub_q   <= bub_d;
            hlt_q   <= hlt_d;
        end
    end

    assign mem_result_out = res_q;
    assign mem_out_2      = out2_q;
    assign mem_opcode_out = opc_q;
    assign mem_tgt        = tgt_q;
    assign mem_bubble_out = bub_q;
    assign mem_halt_out   = hlt_q;
    assign bus_err        = berr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: random instruction stream, random memory
// latency/timeouts and random halts against an instruction-level memory model.
module tb_mem_stage;

    localparam int unsigned TMO = 4;

    logic        clk = 1'b0;
    logic        rst, halt;
    logic [15:0] ex_result, ex_store_data;
    logic [2:0]  ex_opcode, ex_tgt;
    logic        ex_bubble, ex_halt;
    logic        mem_stall, dmem_req, dmem_we;
    logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_ack;
    logic [15:0] mem_result_out, mem_out_2;
    logic [2:0]  mem_opcode_out, mem_tgt;
    logic        mem_bubble_out, mem_halt_out, bus_err;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT(TMO), .ERR_DATA(16'hFFFF)) dut (
        .clk(clk), .rst(rst), .halt(halt),
        .ex_result(ex_result), .ex_store_data(ex_store_data),
        .ex_opcode(ex_opcode), .ex_tgt(ex_tgt), .ex_bubble(ex_bubble), .ex_halt(ex_halt),
        .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .mem_result_out(mem_result_out), .mem_out_2(mem_out_2),
        .mem_opcode_out(mem_opcode_out), .mem_tgt(mem_tgt),
        .mem_bubble_out(mem_bubble_out), .mem_halt_out(mem_halt_out), .bus_err(bus_err)
    );

    typedef struct {
        logic [15:0] res;
        logic [15:0] d2;
        logic [2:0]  opc;
        logic [2:0]  tgt;
        logic        hlt;
        logic        berr;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic        exp_berr = 1'b0;
    logic [15:0] mem_m [16];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: a non-bubble output after a cycle without halt/reset is a fresh commit
    initial begin
        logic h_prev = 1'b1;
        logic r_prev = 1'b1;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!r_prev) begin
                if (!mem_bubble_out && !h_prev) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_unexpected actual=commit required=none");
                    end else begin
                        e = sb.pop_front();
                        chk("result", mem_result_out, e.res);
                        chk("out_2", mem_out_2, e.d2);
                        chk("opcode", {13'd0, mem_opcode_out}, {13'd0, e.opc});
                        chk("tgt", {13'd0, mem_tgt}, {13'd0, e.tgt});
                        chk("halt_out", {15'd0, mem_halt_out}, {15'd0, e.hlt});
                        chk("bus_err", {15'd0, bus_err}, {15'd0, e.berr});
                    end
                end else if (mem_bubble_out) begin
                    chk("bubble_tgt", {13'd0, mem_tgt}, 16'd0);
                    chk("bubble_halt", {15'd0, mem_halt_out}, 16'd0);
                end
            end
            h_prev = halt;
            r_prev = rst;
        end
    end

    // Present one instruction and act as memory until the stage accepts it
    task automatic run_instr(input logic bub, input logic [2:0] opc, input logic [15:0] res,
                             input logic [15:0] sd, input logic [2:0] tgt, input logic eh,
                             input int lat);
        int          reqc = 0;
        int          cyc = 0;
        bit          done = 0;
        bit          acc;
        bit          ismem, tmo;
        logic [15:0] lwval = '0;
        exp_t        e;
        ex_bubble = bub; ex_opcode = opc; ex_result = res;
        ex_store_data = sd; ex_tgt = tgt; ex_halt = eh;
        ismem = !bub && (opc == 3'b100 || opc == 3'b101);
        while (!done && cyc < 64) begin
            halt = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            if (dmem_req) begin
                if (!ismem) begin
                    chk("req_nonmem", {15'd0, dmem_req}, 16'd0);
                end else begin
                    chk("dmem_addr", dmem_addr, res);
                    chk("dmem_wdata", dmem_wdata, sd);
                    chk("dmem_we", {15'd0, dmem_we}, {15'd0, opc == 3'b100});
                end
                dmem_ack   = (lat >= 0 && reqc == lat);
                dmem_rdata = dmem_ack ? mem_m[res[3:0]] : 16'($urandom);
                if (dmem_ack) begin
                    lwval = mem_m[res[3:0]];
                    if (opc == 3'b100) mem_m[res[3:0]] = sd;
                end
                reqc++;
            end else begin
                if (ismem && !halt && reqc == 0)
                    chk("req_issue", {15'd0, dmem_req}, 16'd1);
                dmem_ack   = ($urandom_range(0, 3) == 0);
                dmem_rdata = 16'($urandom);
            end
            if (!ismem) chk("stall_nonmem", {15'd0, mem_stall}, 16'd0);
            acc = !halt && !mem_stall && !(dmem_req && !dmem_ack);
            @(posedge clk);
            #1;
            dmem_ack = 1'b0;
            if (acc) begin
                if (!bub) begin
                    tmo = ismem && lat < 0;
                    if (tmo) exp_berr = 1'b1;
                    e.res  = res;
                    e.opc  = opc;
                    e.tgt  = tgt;
                    e.hlt  = eh;
                    e.d2   = (ismem && opc == 3'b101) ? (tmo ? 16'hFFFF : lwval) : 16'h0000;
                    e.berr = exp_berr;
                    sb.push_back(e);
                end
                done = 1;
            end
            cyc++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=stuck required=accepted");
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] others [6];
        int         r, lat;
        logic       bub, eh;
        logic [2:0] opc;
        logic [15:0] res;
        others[0] = 3'd0; others[1] = 3'd1; others[2] = 3'd2;
        others[3] = 3'd3; others[4] = 3'd6; others[5] = 3'd7;
        for (int i = 0; i < 16; i++) mem_m[i] = 16'($urandom);

        rst = 1'b1; halt = 1'b0; ex_bubble = 1'b1; ex_opcode = 3'b101;
        ex_result = '0; ex_store_data = '0; ex_tgt = '0; ex_halt = 1'b0;
        dmem_ack = 1'b0; dmem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_bubble", {15'd0, mem_bubble_out}, 16'd1);
        chk("rst_tgt", {13'd0, mem_tgt}, 16'd0);
        chk("rst_opcode", {13'd0, mem_opcode_out}, 16'd0);
        chk("rst_result", mem_result_out, 16'd0);
        chk("rst_out2", mem_out_2, 16'd0);
        chk("rst_halt", {15'd0, mem_halt_out}, 16'd0);
        chk("rst_buserr", {15'd0, bus_err}, 16'd0);
        chk("rst_req", {15'd0, dmem_req}, 16'd0);
        chk("rst_stall", {15'd0, mem_stall}, 16'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int n = 0; n < 300; n++) begin
            r   = $urandom_range(0, 9);
            bub = (r < 2);
            if (r < 2)      opc = 3'($urandom);
            else if (r < 5) opc = 3'b101;
            else if (r < 8) opc = 3'b100;
            else            opc = others[$urandom_range(0, 5)];
            res = (r >= 2 && r < 8) ? 16'($urandom_range(0, 15)) : 16'($urandom);
            eh  = ($urandom_range(0, 7) == 0);
            lat = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 4);
            run_instr(bub, opc, res, 16'($urandom), 3'($urandom), eh, lat);
        end

        halt = 1'b0; ex_bubble = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("sb_empty", 16'(sb.size()), 16'd0);
        chk("bus_err_final", {15'd0, bus_err}, {15'd0, exp_berr});

        // Reset while waiting on memory drops the request; a late ack is ignored
        ex_bubble = 1'b0; ex_opcode = 3'b101; ex_result = 16'h0007; ex_tgt = 3'd5;
        @(negedge clk);
        chk("rw_req_idle", {15'd0, dmem_req}, 16'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rw_stall", {15'd0, mem_stall}, 16'd1);
        chk("rw_req_wait", {15'd0, dmem_req}, 16'd1);
        @(posedge clk);
        #1;
        rst = 1'b1; ex_bubble = 1'b1;
        @(negedge clk);
        chk("rw_req_in_rst", {15'd0, dmem_req}, 16'd0);
        @(posedge clk);
        #1;
        rst = 1'b0; exp_berr = 1'b0;
        dmem_ack = 1'b1; dmem_rdata = 16'h1234;
        @(negedge clk);
        chk("rw_req_after", {15'd0, dmem_req}, 16'd0);
        chk("rw_bubble", {15'd0, mem_bubble_out}, 16'd1);
        chk("rw_tgt", {13'd0, mem_tgt}, 16'd0);
        chk("rw_stall_after", {15'd0, mem_stall}, 16'd0);
        @(posedge clk);
        #1;
        dmem_ack = 1'b0;
        @(negedge clk);
        chk("rw_late_bubble", {15'd0, mem_bubble_out}, 16'd1);
        chk("rw_late_out2", mem_out_2, 16'd0);
        chk("rw_buserr", {15'd0, bus_err}, {15'd0, exp_berr});
        chk("rw_sb_empty", 16'(sb.size()), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
